lcd_init_seq: RTL and testbench
===============================

Name: lcd_init_seq

Overview:
Downstream neighbour of the LCD reset stage. Waits for the reset stage's active-low completion flag, then walks a fixed internal init table for the ILI9325-class TFT. Each entry is an index write, a data write, a millisecond delay or an end marker. Register writes are issued over a req/ack handshake to the LCD bus writer; completion is flagged on init_done_o.

Parameters:
TICKS_PER_MS, 50_000, clk cycles per millisecond (50 MHz clock)
ROM_DEPTH, 32, number of init table entries; address width is clog2(ROM_DEPTH)
ACK_TIMEOUT, 1_000, clk cycles to wait for wr_ack_i (used only with the optional feature)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous reset, active-high (asserted when 1)
rst_done_n_i  in  1  reset-stage completion, 0 = LCD reset finished
wr_req_o  out  1  write request to bus writer
wr_rs_o  out  1  register select: 0 = index write, 1 = data write
wr_data_o  out  16  write payload
wr_ack_i  in  1  one-cycle pulse from bus writer: write accepted
busy_o  out  1  1 while the sequence is running
init_done_o  out  1  1 once the END entry is reached
err_o  out  1  ack timeout flag (tied 0 without the optional feature)

Behaviour:
- Reset (rst_n=1 at a clk edge): state IDLE, entry pointer 0, all outputs 0, counters 0.
- Entry format is 18 bits {op[1:0], val[15:0]}: op 00 = CMD (rs=0), 01 = DATA (rs=1), 10 = DELAY val ms, 11 = END.
- Default table:
  - 0 CMD 0x00E5; 1 DATA 0x78F0
  - 2 CMD 0x0001; 3 DATA 0x0100
  - 4 DELAY 50
  - 5 CMD 0x0007; 6 DATA 0x0133
  - 7 END
  - remaining entries END.
- IDLE -> FETCH: on the cycle rst_done_n_i is sampled 0. busy_o rises on the same edge as the state change.
- FETCH: 1 cycle; registered table read at pointer. Next state by op:
  - CMD/DATA -> WRITE
  - DELAY -> DELAY
  - END -> DONE
- WRITE:
  - wr_req_o=1; wr_rs_o and wr_data_o are loaded on entry and held stable until ack.
  - On wr_ack_i=1: wr_req_o=0 next cycle, pointer+1, -> FETCH.
  - This guarantees at least 1 cycle of wr_req_o=0 between writes.
  - wr_ack_i while not in WRITE is ignored.
- DELAY:
  - Holds for exactly val*TICKS_PER_MS cycles, then pointer+1 and -> FETCH.
  - val=0 means one cycle in DELAY.
  - Use an ms counter plus a tick counter; no 40-bit product.
- DONE: init_done_o=1, busy_o=0, outputs held. Stays until rst_done_n_i=1, then -> IDLE with init_done_o=0 on the next cycle.
- Abort: rst_done_n_i=1 in any non-IDLE state forces IDLE on the next edge.
  - wr_req_o=0 and pointer reset to 0.
  - A concurrent wr_ack_i is discarded.
- Pointer reaching ROM_DEPTH-1 without END: treat the entry after the last as END; no wrap.
- rst_n has priority over all other inputs.

Optional Feature:
LCD_INIT_ACK_TIMEOUT_EN
- Defined: a counter runs in WRITE. If ACK_TIMEOUT cycles elapse without wr_ack_i, go to ERROR.
  - ERROR: wr_req_o=0, err_o=1, busy_o=0, init_done_o=0.
  - Exit only via rst_n or rst_done_n_i=1, both to IDLE with err_o=0.
  - Ack on the exact timeout cycle counts as success.
- Not defined: WRITE waits indefinitely; err_o is constant 0; no timeout counter is synthesized.

Test Plan:
- rst_n=1 for 3 cycles, then rst_done_n_i=0; bus writer acks 2 cycles after each req -> writes in order:
  - (rs0,0x00E5) (rs1,0x78F0) (rs0,0x0001) (rs1,0x0100)
  - 50 ms gap (2_500_000 cycles, ±FETCH)
  - (rs0,0x0007) (rs1,0x0133)
  - then init_done_o=1, busy_o=0.
- Ack held off 20 cycles on write 0 -> wr_req_o stays 1 with wr_data_o=0x00E5 stable for all 20 cycles; no other write starts.
- rst_done_n_i driven 1 during the DELAY entry -> IDLE next cycle, busy_o=0. Re-enable -> sequence restarts at 0x00E5.
- After init_done_o=1, toggle rst_done_n_i 1 then 0 -> init_done_o drops, then the full sequence repeats.
- rst_n=1 asserted mid-WRITE alongside wr_ack_i -> all outputs 0 next cycle; no pointer advance.
- With LCD_INIT_ACK_TIMEOUT_EN and ACK_TIMEOUT=1000, never ack -> err_o=1 exactly 1000 cycles after wr_req_o rises; wr_req_o=0.

Source files
------------

// File: rtl/lcd_init_seq.sv
// Init-table sequencer for an ILI9325-class TFT: after the reset stage reports completion it
// replays a fixed table of index/data writes and ms delays. Optional ack timeout: LCD_INIT_ACK_TIMEOUT_EN.
module lcd_init_seq #(
    parameter int unsigned TICKS_PER_MS = 50_000,
    parameter int unsigned ROM_DEPTH    = 32,
    parameter int unsigned ACK_TIMEOUT  = 1_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rst_done_n_i,
    output logic        wr_req_o,
    output logic        wr_rs_o,
    output logic [15:0] wr_data_o,
    input  logic        wr_ack_i,
    output logic        busy_o,
    output logic        init_done_o,
    output logic        err_o
);
    localparam int unsigned   AW        = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1;
    localparam int unsigned   TW        = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(ROM_DEPTH - 1);
    localparam logic [TW-1:0] LAST_TICK = TW'(TICKS_PER_MS - 1);

    if (TICKS_PER_MS < 1 || ROM_DEPTH < 2 || ACK_TIMEOUT < 1) begin : g_bad_param
        $error("lcd_init_seq: invalid parameter value");
    end

    typedef enum logic [1:0] {
        OP_CMD   = 2'b00,
        OP_DATA  = 2'b01,
        OP_DELAY = 2'b10,
        OP_END   = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WRITE,
        S_DELAY,
        S_DONE,
        S_ERROR
    } state_e;

    function automatic logic [17:0] rom_entry(input logic [AW-1:0] addr);
        case (int'(addr))
            0:       rom_entry = {OP_CMD,   16'h00E5};
            1:       rom_entry = {OP_DATA,  16'h78F0};
            2:       rom_entry = {OP_CMD,   16'h0001};
            3:       rom_entry = {OP_DATA,  16'h0100};
            4:       rom_entry = {OP_DELAY, 16'd50};
            5:       rom_entry = {OP_CMD,   16'h0007};
            6:       rom_entry = {OP_DATA,  16'h0133};
            default: rom_entry = {OP_END,   16'h0000};
        endcase
    endfunction

    state_e          r_state;
    state_e          w_next;
    logic [AW-1:0]   r_ptr;
    logic            r_past_end;
    logic            r_rs;
    logic [15:0]     r_data;
    logic [15:0]     r_ms;
    logic [TW-1:0]   r_tick;
    logic [17:0]     w_entry;
    op_e             w_op;
    logic            w_abort;
    logic            w_delay_done;
    logic            w_advance;

    // Stepping past the last slot without an END behaves as if an END followed it.
    assign w_entry      = r_past_end ? {OP_END, 16'h0000} : rom_entry(r_ptr);
    assign w_op         = op_e'(w_entry[17:16]);
    assign w_abort      = (r_state != S_IDLE) && rst_done_n_i;
    assign w_delay_done = (r_ms == 16'd0) || ((r_ms == 16'd1) && (r_tick == LAST_TICK));
    assign w_advance    = ((r_state == S_WRITE) && wr_ack_i) ||
                          ((r_state == S_DELAY) && w_delay_done);

`ifdef LCD_INIT_ACK_TIMEOUT_EN
    localparam int unsigned CW = $clog2(ACK_TIMEOUT + 1);
    logic [CW-1:0] r_tcnt;
    logic          w_timeout;

    assign w_timeout = (r_tcnt == CW'(ACK_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_tcnt <= '0;
        end else if (r_state == S_FETCH) begin
            r_tcnt <= '0;
        end else if (r_state == S_WRITE && !wr_ack_i) begin
            r_tcnt <= r_tcnt + CW'(1);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_ptr      <= '0;
            r_past_end <= 1'b0;
            r_rs       <= 1'b0;
            r_data     <= '0;
            r_ms       <= '0;
            r_tick     <= '0;
        end else if (w_abort || r_state == S_IDLE) begin
            r_ptr      <= '0;
            r_past_end <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (w_op == OP_CMD || w_op == OP_DATA) begin
                        r_rs   <= w_entry[16];
                        r_data <= w_entry[15:0];
                    end
                    if (w_op == OP_DELAY) begin
                        r_ms   <= w_entry[15:0];
                        r_tick <= '0;
                    end
                end
                S_DELAY: begin
                    // ms counter steps down once per full tick period; no ms*ticks product.
                    if (!w_delay_done) begin
                        if (r_tick == LAST_TICK) begin
                            r_tick <= '0;
                            r_ms   <= r_ms - 16'd1;
                        end else begin
                            r_tick <= r_tick + TW'(1);
                        end
                    end
                end
                default: ;
            endcase
            if (w_advance) begin
                if (r_ptr == LAST_ADDR) begin
                    r_past_end <= 1'b1;
                end else begin
                    r_ptr <= r_ptr + AW'(1);
                end
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        wr_req_o    = 1'b0;
        busy_o      = 1'b0;
        init_done_o = 1'b0;
        err_o       = 1'b0;
        wr_rs_o     = r_rs;
        wr_data_o   = r_data;
        case (r_state)
            S_IDLE: begin
                if (!rst_done_n_i) w_next = S_FETCH;
            end
            S_FETCH: begin
                busy_o = 1'b1;
                case (w_op)
                    OP_CMD, OP_DATA: w_next = S_WRITE;
                    OP_DELAY:        w_next = S_DELAY;
                    default:         w_next = S_DONE;
                endcase
            end
            S_WRITE: begin
                busy_o   = 1'b1;
                wr_req_o = 1'b1;
                if (wr_ack_i) begin
                    w_next = S_FETCH;
`ifdef LCD_INIT_ACK_TIMEOUT_EN
                end else if (w_timeout) begin
                    w_next = S_ERROR;
`endif
                end
            end
            S_DELAY: begin
                busy_o = 1'b1;
                if (w_delay_done) w_next = S_FETCH;
            end
            S_DONE: begin
                init_done_o = 1'b1;
            end
            S_ERROR: begin
`ifdef LCD_INIT_ACK_TIMEOUT_EN
                err_o = 1'b1;
`endif
            end
            default: w_next = S_IDLE;
        endcase
        if (w_abort) w_next = S_IDLE;
    end

endmodule

// File: tb/tb_lcd_init_seq.sv
// Self-checking bench for lcd_init_seq: randomized ack latency, a table-driven timeline model,
// and literal checks for reset, handshake hold, aborts and mid-write reset.
module tb_lcd_init_seq;
    localparam int TPM = 10;
    localparam int ATO = 1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdn = 1'b1;
    logic        ack = 1'b0;
    logic        req, rs, busy, done, err;
    logic [15:0] data;

    lcd_init_seq #(
        .TICKS_PER_MS (TPM),
        .ROM_DEPTH    (32),
        .ACK_TIMEOUT  (ATO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst),
        .rst_done_n_i (rdn),
        .wr_req_o     (req),
        .wr_rs_o      (rs),
        .wr_data_o    (data),
        .wr_ack_i     (ack),
        .busy_o       (busy),
        .init_done_o  (done),
        .err_o        (err)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Init table as plain data: op 0=CMD 1=DATA 2=DELAY(ms) 3=END; slots 8+ are END.
    int t_op [8] = '{0, 1, 0, 1, 2, 0, 1, 3};
    int t_val[8] = '{'h00E5, 'h78F0, 'h0001, 'h0100, 50, 'h0007, 'h0133, 0};

    // Edges from the current transition until the next request rises (or done is reached).
    function automatic int gap_to(input int idx, output int nidx, output bit is_end);
        int c = 1;
        int i = idx;
        while (i < 8 && t_op[i] == 2) begin
            c += 1 + ((t_val[i] * TPM > 0) ? t_val[i] * TPM : 1);
            i++;
        end
        nidx   = i;
        is_end = 1'b1;
        if (i < 8) is_end = (t_op[i] == 3);
        return c;
    endfunction

    bit m_run = 0, m_done = 0, m_req = 0, m_err = 0, m_end = 0;
    int m_idx = 0, m_pend = 0, m_wcnt = 0;

    function automatic void sched();
        int ni;
        bit e;
        m_pend = gap_to(m_idx, ni, e);
        m_idx  = ni;
        m_end  = e;
    endfunction

    initial forever begin
        @(posedge clk);
        if (rst) begin
            m_run = 0; m_done = 0; m_req = 0; m_err = 0;
        end else if (!m_run && !m_done && !m_err) begin
            if (!rdn) begin m_run = 1; m_idx = 0; sched(); end
        end else if (rdn) begin
            m_run = 0; m_done = 0; m_req = 0; m_err = 0;
        end else if (m_req) begin
            if (ack) begin
                m_req = 0; m_idx++; sched();
            end
`ifdef LCD_INIT_ACK_TIMEOUT_EN
            else begin
                m_wcnt++;
                if (m_wcnt == ATO) begin m_req = 0; m_run = 0; m_err = 1; end
            end
`endif
        end else if (m_run) begin
            m_pend--;
            if (m_pend == 0) begin
                if (m_end) begin m_run = 0; m_done = 1; end
                else begin m_req = 1; m_wcnt = 0; end
            end
        end
    end

    logic [16:0] wlog[$];
    int          glog[$];
    int          hlog[$];

    initial begin
        bit prev_req = 0;
        int low_run = 0, hi_run = 0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            check("busy_o",      32'(busy), 32'(m_run));
            check("wr_req_o",    32'(req),  32'(m_req));
            check("init_done_o", 32'(done), 32'(m_done));
            check("err_o",       32'(err),  32'(m_err));
            if (m_req) begin
                check("wr_rs_o",   32'(rs),   32'(t_op[m_idx] == 1));
                check("wr_data_o", 32'(data), 32'(t_val[m_idx]));
            end
            if (req) begin
                if (!prev_req) begin
                    wlog.push_back({rs, data});
                    glog.push_back(low_run);
                    hi_run = 0;
                end
                hi_run++;
                low_run = 0;
            end else begin
                if (prev_req) hlog.push_back(hi_run);
                low_run++;
            end
            prev_req = req;
        end
    end

    bit resp_en   = 1;
    bit rand_mode = 0;
    int hold_first = 0;

    initial begin
        int hi = 0, cur = 2;
        forever begin
            @(negedge clk);
            if (!resp_en) hi = 0;
            else if (ack) begin ack = 0; hi = 0; end
            else if (req) begin
                if (hi == 0) begin
                    if (hold_first > 0) begin cur = hold_first; hold_first = 0; end
                    else cur = rand_mode ? int'($urandom_range(1, 5)) : 2;
                end
                hi++;
                if (hi >= cur) ack = 1;
            end else hi = 0;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_logs();
        wlog.delete(); glog.delete(); hlog.delete();
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (!done && n < budget) begin tick(); n++; end
        check(name, 32'(done), 32'd1);
    endtask

    task automatic wait_writes(input string name, input int cnt, input int budget);
        int n = 0;
        while (wlog.size() < cnt && n < budget) begin tick(); n++; end
        check(name, 32'(wlog.size() >= cnt), 32'd1);
    endtask

    task automatic restart();
        rdn = 1; tick(); rdn = 0;
    endtask

    logic [16:0] exp_w[6] = '{17'h000E5, 17'h178F0, 17'h00001, 17'h10100, 17'h00007, 17'h10133};

    initial begin
        int ni;
        bit e;
        check("model gap entry0", 32'(gap_to(0, ni, e)), 32'd1);
        check("model gap entry4", 32'(gap_to(4, ni, e)), 32'd502);
        check("model next after delay", 32'(ni), 32'd5);
        check("model gap entry7", 32'(gap_to(7, ni, e)), 32'd1);
        check("model end at 7", 32'(e), 32'd1);

        rst = 1; rdn = 1; ack = 0;
        repeat (3) tick();
        check("reset wr_req_o",  32'(req),  32'd0);
        check("reset busy_o",    32'(busy), 32'd0);
        check("reset done",      32'(done), 32'd0);
        check("reset wr_data_o", 32'(data), 32'd0);
        check("reset wr_rs_o",   32'(rs),   32'd0);
        rst = 0;
        clear_logs();
        rdn = 0;
        tick();
        check("busy on start", 32'(busy), 32'd1);
        wait_done("seq1 done", 3000);
        check("seq1 write count", 32'(wlog.size()), 32'd6);
        for (int i = 0; i < 6; i++) check("seq1 write", 32'(wlog[i]), 32'(exp_w[i]));
        check("seq1 low gap between writes", 32'(glog[1]), 32'd1);
        check("seq1 delay gap", 32'(glog[4]), 32'd502);
        check("seq1 req high cycles", 32'(hlog[0]), 32'd2);
        check("seq1 busy after done", 32'(busy), 32'd0);

        rdn = 1; tick();
        check("done drops on rdn", 32'(done), 32'd0);
        rand_mode = 1;
        clear_logs();
        rdn = 0;
        wait_done("seq2 done", 3000);
        check("seq2 write count", 32'(wlog.size()), 32'd6);
        for (int i = 0; i < 6; i++) check("seq2 write", 32'(wlog[i]), 32'(exp_w[i]));

        clear_logs();
        hold_first = 20;
        restart();
        wait_done("hold done", 3000);
        check("hold req high cycles", 32'(hlog[0]), 32'd20);
        check("hold first write", 32'(wlog[0]), 32'h000E5);
        check("hold second write", 32'(wlog[1]), 32'h178F0);

        clear_logs();
        restart();
        wait_writes("abort reach 4 writes", 4, 200);
        while (req) tick();
        repeat (100) tick();
        rdn = 1; tick();
        check("abort busy_o", 32'(busy), 32'd0);
        check("abort wr_req_o", 32'(req), 32'd0);
        clear_logs();
        rdn = 0;
        wait_writes("abort restart write", 1, 50);
        check("abort restart data", 32'(wlog[0]), 32'h000E5);
        wait_done("abort seq done", 3000);

        resp_en = 0; ack = 0;
        clear_logs();
        restart();
        wait_writes("rst mid write req", 1, 50);
        repeat (2) tick();
        rst = 1; ack = 1;
        tick();
        check("midrst wr_req_o", 32'(req),  32'd0);
        check("midrst busy_o",   32'(busy), 32'd0);
        check("midrst data",     32'(data), 32'd0);
        rst = 0; ack = 0;
        resp_en = 1;
        clear_logs();
        wait_writes("midrst restart write", 1, 50);
        check("midrst restart data", 32'(wlog[0]), 32'h000E5);
        wait_done("midrst seq done", 3000);

`ifdef LCD_INIT_ACK_TIMEOUT_EN
        begin
            int k = 0;
            resp_en = 0; ack = 0;
            clear_logs();
            restart();
            wait_writes("timeout req", 1, 50);
            while (!err && k < ATO + 100) begin tick(); k++; end
            check("timeout cycles", 32'(k), 32'(ATO));
            check("timeout wr_req_o", 32'(req), 32'd0);
            check("timeout busy_o", 32'(busy), 32'd0);
            rdn = 1; tick();
            check("timeout err clears", 32'(err), 32'd0);
            resp_en = 1;
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
